// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default widths for the packet FIFO access scheduler.
package fifo_ctrl_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned W_DEF     = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_e;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr+1 upward, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] grant_idx_o,
    output logic                     any_req_o
);

    localparam int unsigned IW = $clog2(N_REQ);

    int unsigned    idx;
    logic [IW-1:0]  idx_b;
    logic           found;

    assign any_req_o = |req_i;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        idx_b       = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx   = (32'(ptr_i) + i) % N_REQ;
            idx_b = IW'(idx);
            if (!found && req_i[idx_b]) begin
                found          = 1'b1;
                grant_o[idx_b] = 1'b1;
                grant_idx_o    = idx_b;
            end
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Schedules producer writes and sink reads onto a shared FIFO, one operation
// per two cycles so the FIFO flags always reflect the previous operation.
module fifo_access_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned W     = W_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*W-1:0] i_pkt,
    output logic [N_REQ-1:0]   o_ack,
    output logic               o_fifo_wn,
    output logic [W-1:0]       o_fifo_packet,
    output logic               o_fifo_rn,
    input  logic               i_fifo_full,
    input  logic               i_fifo_empty,
    input  logic [W-1:0]       i_fifo_packet,
    input  logic               i_sink_ready,
    output logic               o_sink_valid,
    output logic [W-1:0]       o_sink_packet
);

    localparam int unsigned IW = $clog2(N_REQ);

    state_e             state_q, state_d;
    op_e                last_op_q, last_op_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               wn_q, wn_d;
    logic               rn_q, rn_d;
    logic               sv_q, sv_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [W-1:0]       pkt_q, pkt_d;

    logic [N_REQ-1:0]   grant;
    logic [IW-1:0]      grant_idx;
    logic               any_req;
    logic               wr_cand, rd_cand, go_wr, go_rd;
    logic [W-1:0]       pkt_arr [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign pkt_arr[k] = i_pkt[k*W +: W];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i       (i_req),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_req_o   (any_req)
    );

    assign wr_cand = any_req & ~i_fifo_full;
    assign rd_cand = ~i_fifo_empty & i_sink_ready;

    always_comb begin
        state_d   = S_IDLE;
        last_op_d = last_op_q;
        rr_ptr_d  = rr_ptr_q;
        wn_d      = 1'b0;
        rn_d      = 1'b0;
        ack_d     = '0;
        pkt_d     = pkt_q;
        sv_d      = (state_q == S_RD);
        go_wr     = 1'b0;
        go_rd     = 1'b0;
        if (state_q == S_IDLE) begin
            // On a tie, alternate with whichever operation went last.
            if (wr_cand && rd_cand) begin
                go_wr = (last_op_q == OP_RD);
                go_rd = (last_op_q == OP_WR);
            end else begin
                go_wr = wr_cand;
                go_rd = rd_cand;
            end
            if (go_wr) begin
                state_d   = S_WR;
                wn_d      = 1'b1;
                ack_d     = grant;
                pkt_d     = pkt_arr[grant_idx];
                rr_ptr_d  = grant_idx;
                last_op_d = OP_WR;
            end else if (go_rd) begin
                state_d   = S_RD;
                rn_d      = 1'b1;
                last_op_d = OP_RD;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            last_op_q <= OP_RD;
            rr_ptr_q  <= IW'(N_REQ - 1);
            wn_q      <= 1'b0;
            rn_q      <= 1'b0;
            sv_q      <= 1'b0;
            ack_q     <= '0;
            pkt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_op_q <= last_op_d;
            rr_ptr_q  <= rr_ptr_d;
            wn_q      <= wn_d;
            rn_q      <= rn_d;
            sv_q      <= sv_d;
            ack_q     <= ack_d;
            pkt_q     <= pkt_d;
        end
    end

    assign o_ack         = ack_q;
    assign o_fifo_wn     = wn_q;
    assign o_fifo_rn     = rn_q;
    assign o_fifo_packet = pkt_q;
    assign o_sink_valid  = sv_q;
    assign o_sink_packet = i_fifo_packet;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed, table-driven bench for fifo_access_ctrl with hand-computed outputs.
module tb_fifo_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] pkt;
    logic [3:0]  ack;
    logic        wn, rn, full, empty, rdy, sv;
    logic [7:0]  fpkt_o, fpkt_i, spkt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fifo_access_ctrl #(.N_REQ(4), .W(8)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_req         (req),
        .i_pkt         (pkt),
        .o_ack         (ack),
        .o_fifo_wn     (wn),
        .o_fifo_packet (fpkt_o),
        .o_fifo_rn     (rn),
        .i_fifo_full   (full),
        .i_fifo_empty  (empty),
        .i_fifo_packet (fpkt_i),
        .i_sink_ready  (rdy),
        .o_sink_valid  (sv),
        .o_sink_packet (spkt)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] pkt;
        logic        full, empty, rdy;
        logic [7:0]  fp;
        logic        e_wn, e_rn, e_sv;
        logic [3:0]  e_ack;
        logic [7:0]  e_fpkt;
    } vec_t;

    vec_t tv [30];

    function automatic vec_t mk(logic [3:0] r, logic [31:0] p, logic f, logic e,
                                logic rd, logic [7:0] fp, logic ewn, logic ern,
                                logic esv, logic [3:0] eack, logic [7:0] efp);
        vec_t v;
        v.req = r; v.pkt = p; v.full = f; v.empty = e; v.rdy = rd; v.fp = fp;
        v.e_wn = ewn; v.e_rn = ern; v.e_sv = esv; v.e_ack = eack; v.e_fpkt = efp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ewn, input logic ern,
                              input logic esv, input logic [3:0] eack, input logic [7:0] efp);
        check({tag, ".wn"},   32'(wn),     32'(ewn));
        check({tag, ".rn"},   32'(rn),     32'(ern));
        check({tag, ".sv"},   32'(sv),     32'(esv));
        check({tag, ".ack"},  32'(ack),    32'(eack));
        check({tag, ".fpkt"}, 32'(fpkt_o), 32'(efp));
        check({tag, ".spkt"}, 32'(spkt),   32'(fpkt_i));
    endtask

    localparam logic [31:0] P0 = 32'hA3A2A1A0;
    localparam logic [31:0] P1 = 32'hB3C2B1B0;
    localparam logic [31:0] P2 = 32'hA35CA1A0;

    initial begin
        // round-robin, FIFO never full, sink not ready
        tv[0]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 1, 0, 0, 4'h1, 8'hA0);
        tv[1]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'hA0);
        tv[2]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 1, 0, 0, 4'h2, 8'hA1);
        tv[3]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'hA1);
        tv[4]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 1, 0, 0, 4'h4, 8'hA2);
        tv[5]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'hA2);
        tv[6]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 1, 0, 0, 4'h8, 8'hA3);
        tv[7]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'hA3);
        tv[8]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 1, 0, 0, 4'h1, 8'hA0);
        tv[9]  = mk(4'hF, P0, 0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'hA0);
        // full and empty both block; then full with read possible
        tv[10] = mk(4'h3, P0, 1, 1, 1, 8'h00, 0, 0, 0, 4'h0, 8'hA0);
        tv[11] = mk(4'h3, P0, 1, 1, 1, 8'h00, 0, 0, 0, 4'h0, 8'hA0);
        tv[12] = mk(4'h3, P0, 1, 0, 1, 8'h11, 0, 1, 0, 4'h0, 8'hA0);
        tv[13] = mk(4'h0, P0, 0, 1, 0, 8'h11, 0, 0, 1, 4'h0, 8'hA0);
        tv[14] = mk(4'h0, P0, 0, 1, 0, 8'h11, 0, 0, 0, 4'h0, 8'hA0);
        // alternation with both candidates present
        tv[15] = mk(4'h4, P1, 0, 0, 1, 8'h20, 1, 0, 0, 4'h4, 8'hC2);
        tv[16] = mk(4'h4, P1, 0, 0, 1, 8'h20, 0, 0, 0, 4'h0, 8'hC2);
        tv[17] = mk(4'h4, P1, 0, 0, 1, 8'h20, 0, 1, 0, 4'h0, 8'hC2);
        tv[18] = mk(4'h4, P1, 0, 0, 1, 8'h21, 0, 0, 1, 4'h0, 8'hC2);
        tv[19] = mk(4'h4, P1, 0, 0, 1, 8'h21, 1, 0, 0, 4'h4, 8'hC2);
        tv[20] = mk(4'h4, P1, 0, 0, 1, 8'h21, 0, 0, 0, 4'h0, 8'hC2);
        tv[21] = mk(4'h4, P1, 0, 0, 1, 8'h21, 0, 1, 0, 4'h0, 8'hC2);
        tv[22] = mk(4'h4, P1, 0, 0, 1, 8'h22, 0, 0, 1, 4'h0, 8'hC2);
        // request withdrawn right after the write decision
        tv[23] = mk(4'h4, P2, 0, 1, 0, 8'h00, 1, 0, 0, 4'h4, 8'h5C);
        tv[24] = mk(4'h0, 32'hFFFFFFFF, 0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h5C);
        tv[25] = mk(4'h0, 32'hFFFFFFFF, 0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'h5C);
        // sparse requests with pointer wrap
        tv[26] = mk(4'hB, P0, 0, 1, 0, 8'h00, 1, 0, 0, 4'h8, 8'hA3);
        tv[27] = mk(4'hB, P0, 0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'hA3);
        tv[28] = mk(4'hB, P0, 0, 1, 0, 8'h00, 1, 0, 0, 4'h1, 8'hA0);
        tv[29] = mk(4'h0, P0, 0, 1, 0, 8'h00, 0, 0, 0, 4'h0, 8'hA0);

        rst_n = 1'b0; req = 4'hF; pkt = P0; full = 1'b0; empty = 1'b1;
        rdy = 1'b0; fpkt_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 4'h0, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            req = tv[i].req; pkt = tv[i].pkt; full = tv[i].full;
            empty = tv[i].empty; rdy = tv[i].rdy; fpkt_i = tv[i].fp;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), tv[i].e_wn, tv[i].e_rn, tv[i].e_sv,
                       tv[i].e_ack, tv[i].e_fpkt);
            @(negedge clk);
        end

        // reset asserted in the middle of a read
        req = 4'h0; full = 1'b0; empty = 1'b0; rdy = 1'b1; fpkt_i = 8'h33;
        @(posedge clk);
        #1;
        check_outs("mrd_rd", 0, 1, 0, 4'h0, 8'hA0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("mrd_rst", 0, 0, 0, 4'h0, 8'h00);
        @(negedge clk);
        req = 4'hF; pkt = P0; empty = 1'b1; rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("mrd_after", 1, 0, 0, 4'h1, 8'hA0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
- Scheduler in front of the shared 8x8 packet FIFO.
- Arbitrates N_REQ packet producers round-robin onto the FIFO write port.
- Drains the FIFO read port toward one downstream sink.
- Guarantees write-enable and read-enable are never asserted in the same cycle, and that no operation is issued against a stale full/empty flag.

Parameters:
- N_REQ, 4, number of producer requesters (2..8).
- W, 8, packet width in bits; matches FIFO data width.

Ports:
- i_clock  in  1  single clock; all state updates on posedge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_req  in  N_REQ  per-producer write request; held high until its o_ack.
- i_pkt  in  N_REQ*W  flattened producer packets; slice k = bits [k*W +: W]; stable while i_req[k] is high.
- o_ack  out  N_REQ  one-hot, one-cycle pulse: producer's packet is being written this cycle.
- o_fifo_wn  out  1  FIFO write enable.
- o_fifo_packet  out  W  FIFO write data.
- o_fifo_rn  out  1  FIFO read enable.
- i_fifo_full  in  1  FIFO full flag.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_packet  in  W  FIFO registered read data.
- i_sink_ready  in  1  sink can accept one beat within the next 2 cycles.
- o_sink_valid  out  1  one-cycle pulse: o_sink_packet is valid.
- o_sink_packet  out  W  equals i_fifo_packet (combinational pass-through).

Behaviour:
- Reset (async assert, sync release):
  - o_ack=0, o_fifo_wn=0, o_fifo_rn=0, o_fifo_packet=0, o_sink_valid=0.
  - state=S_IDLE.
  - Round-robin pointer = N_REQ-1, so requester 0 wins first.
  - last_op=OP_RD, so a write wins the first tie.
- FSM states: S_IDLE, S_WR, S_RD. Each operation occupies exactly one cycle, followed by at least one S_IDLE cycle. The resulting 2-cycle cadence guarantees the FIFO flags reflect the previous operation when sampled.
- Candidates, evaluated in S_IDLE only:
  - wr_cand = |i_req & !i_fifo_full.
  - rd_cand = !i_fifo_empty & i_sink_ready.
- S_IDLE decision:
  - Only wr_cand: go to S_WR.
  - Only rd_cand: go to S_RD.
  - Both: choose the opposite of last_op (strict alternation).
  - Neither: stay in S_IDLE.
- Entering S_WR:
  - grant = first set bit of i_req searching from rr_ptr+1, wrapping modulo N_REQ.
  - Latch o_fifo_packet = i_pkt slice[grant].
  - Registered outputs o_fifo_wn=1 and o_ack[grant]=1 for that one cycle.
  - rr_ptr=grant, last_op=OP_WR.
- Entering S_RD: registered o_fifo_rn=1 for one cycle; last_op=OP_RD.
- S_WR and S_RD always return to S_IDLE on the next edge.
- o_sink_valid is registered high for exactly one cycle, the cycle after S_RD, when the FIFO's registered output has updated. The sink must take that beat; i_sink_ready is only sampled in S_IDLE.
- o_fifo_wn and o_fifo_rn are never both high. o_ack is at most one-hot and is high iff o_fifo_wn is high.
- Requester drops i_req after grant: the latched packet is still written and o_ack still pulses.
- i_fifo_full is checked only at decision time. Any full at decision blocks all writes, and reads proceed if possible.
- Max throughput: one FIFO operation per 2 cycles.
- Async reset mid-operation aborts immediately. No partial write is signalled, and any pending o_sink_valid is dropped.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - state enum {S_IDLE, S_WR, S_RD};
  - op enum {OP_WR, OP_RD};
  - default widths N_REQ_DEF=4, W_DEF=8.
- Sub-module rr_arbiter (parameter N_REQ). Inputs: req vector and last-grant pointer. Outputs: combinational one-hot grant, encoded index, and any_req. Instantiated once.
- The FSM, data latch and sink pulse stay in the top.

Test Plan:
- Reset: hold i_reset_n=0 with i_req=4'b1111 -> all outputs 0. Release -> the first S_WR grants requester 0, o_ack=4'b0001, o_fifo_packet=pkt0.
- Round-robin: i_req=4'b1111 held, packets 8'hA0..8'hA3, FIFO never full, sink not ready -> o_ack order 0001,0010,0100,1000,0001. o_fifo_wn pulses every 2nd cycle.
- Alternation: FIFO holds 3 entries, i_req=4'b0100, i_sink_ready=1 -> operation order WR,RD,WR,RD. o_sink_valid pulses 1 cycle after each o_fifo_rn, with o_sink_packet equal to the FIFO head.
- Full/empty: i_fifo_full=1 with i_req=4'b0011 -> no o_fifo_wn, no o_ack. i_fifo_empty=1 with i_sink_ready=1 -> no o_fifo_rn.
- Request withdrawn: i_req[2] falls in the cycle after the S_WR decision -> o_ack[2] still pulses and 8'h5C is written.
- Reset mid-read: i_reset_n low during S_RD -> o_fifo_rn=0 and o_sink_valid=0 immediately. The next grant after release goes to requester 0.
